// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared sizing helpers for the hazard/forwarding controller.
// A tag is packed as {vld, regwr, load, dst, rs, rt, use_rs, use_rt}, so vld is always the MSB.
package pipe_hazard_ctrl_pkg;

  localparam int TAG_FLAG_BITS = 5;

  function automatic int tag_w(input int reg_aw);
    return TAG_FLAG_BITS + 3 * reg_aw;
  endfunction

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between the CPU pipeline and the controller.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = sel_w(DEPTH);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic [REG_AW-1:0] id_dst_i;
  logic              id_regwr_i;
  logic              id_load_i;
  logic              branch_taken_i;

  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              idex_bubble_o;
  logic [SEL_W-1:0]  fwd_a_sel_o;
  logic [SEL_W-1:0]  fwd_b_sel_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dst_i, id_regwr_i, id_load_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
           id_dst_i, id_regwr_i, id_load_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_tag_stage.sv
// One shadow-pipeline tag register; the invalidate input clears only the valid bit (MSB).
module hazard_tag_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic             inv_i,
  input  logic [TAG_W-1:0] d_i,
  output logic [TAG_W-1:0] q_o
);
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_d;

  always_comb begin
    tag_d = d_i;
    if (inv_i) tag_d[TAG_W-1] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_q <= '0;
    end else if (ld_i) begin
      tag_q <= tag_d;
    end
  end

  assign q_o = tag_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight destinations in a shadow tag pipeline and
// derives stall, bubble, flush and per-operand forward selects from it.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int SEL_W = sel_w(DEPTH);
  localparam int TAG_W = tag_w(REG_AW);

  typedef struct packed {
    logic              vld;
    logic              regwr;
    logic              load;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } tag_t;

  tag_t             tag_q [1:DEPTH];
  tag_t             id_tag;
  tag_t             s1_d;
  logic             stall_raw;
  logic             stall;
  logic             flush;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic match(input tag_t t, input logic [REG_AW-1:0] r);
    return t.vld && t.regwr && (t.dst == r) && (r != '0);
  endfunction

  assign id_tag = {bus.id_valid_i, bus.id_regwr_i, bus.id_load_i, bus.id_dst_i,
                   bus.id_rs_i, bus.id_rt_i, bus.id_use_rs_i, bus.id_use_rt_i};

  // A flush wins over a stall; both are masked while reset is held so outputs settle immediately.
  always_comb begin
    stall_raw = 1'b0;
    for (int s = 1; s <= LOAD_LAT; s++) begin
      if (tag_q[s].load &&
          ((bus.id_use_rs_i && match(tag_q[s], bus.id_rs_i)) ||
           (bus.id_use_rt_i && match(tag_q[s], bus.id_rt_i))))
        stall_raw = 1'b1;
    end
    stall_raw = stall_raw && bus.id_valid_i;
    flush     = rst_i && bus.branch_taken_i;
    stall     = rst_i && stall_raw && !bus.branch_taken_i;
    s1_d      = (bus.id_valid_i && !stall_raw && !bus.branch_taken_i) ? id_tag : '0;
  end

  // Scan oldest to youngest so the youngest eligible producer is the last one written.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int s = DEPTH; s >= 2; s--) begin
      if ((!tag_q[s].load || (s >= 2 + LOAD_LAT)) && match(tag_q[s], tag_q[1].rs))
        sel_a = SEL_W'(s);
      if ((!tag_q[s].load || (s >= 2 + LOAD_LAT)) && match(tag_q[s], tag_q[1].rt))
        sel_b = SEL_W'(s);
    end
    if (!(rst_i && tag_q[1].vld && tag_q[1].use_rs)) sel_a = '0;
    if (!(rst_i && tag_q[1].vld && tag_q[1].use_rt)) sel_b = '0;
  end

  for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
    logic [TAG_W-1:0] d_vec;
    logic [TAG_W-1:0] q_vec;
    if (gi == 1) begin : g_head
      assign d_vec = s1_d;
    end else begin : g_tail
      assign d_vec = tag_q[gi-1];
    end
    hazard_tag_stage #(.TAG_W(TAG_W)) u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ld_i  (1'b1),
      .inv_i (flush && (gi < BR_STAGE)),
      .d_i   (d_vec),
      .q_o   (q_vec)
    );
    assign tag_q[gi] = q_vec;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write_o    = !stall;
  assign bus.ifid_write_o  = !stall;
  assign bus.ifid_flush_o  = flush;
  assign bus.idex_bubble_o = flush || stall;
  assign bus.fwd_a_sel_o   = sel_a;
  assign bus.fwd_b_sel_o   = sel_b;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controller configurations share one random instruction stream and are
// compared against an instruction-level model of the in-flight window.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) bus3 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(5), .CNT_W(4))  bus5 ();

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .BR_STAGE(2), .CNT_W(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus3));
  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(5), .LOAD_LAT(2), .BR_STAGE(3), .CNT_W(4)) u_dut5 (
    .clk_i(clk), .rst_i(rst_n), .bus(bus5));

  typedef struct {
    bit vld; bit regwr; bit load;
    int dst; int rs; int rt;
    bit urs; bit urt;
  } ent_t;

  typedef struct {
    int m; int pcw; int ifw; int ifl; int bub; int fa; int fb; int sc; int fc;
  } exp_t;

  ent_t pipe [2][1:8];
  int   depth_m [2];
  int   ll_m    [2];
  int   br_m    [2];
  int   max_m   [2];
  int   sc_m    [2];
  int   fc_m    [2];
  exp_t expq [$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void reset_model();
    ent_t z;
    z = '{default: 0};
    for (int m = 0; m < 2; m++) begin
      for (int s = 1; s <= 8; s++) pipe[m][s] = z;
      sc_m[m] = 0;
      fc_m[m] = 0;
    end
  endfunction

  function automatic bit mmatch(input int m, input int s, input int r);
    return pipe[m][s].vld && pipe[m][s].regwr && (pipe[m][s].dst == r) && (r != 0);
  endfunction

  // Youngest in-flight producer whose result is already available in its stage.
  function automatic int mfwd(input int m, input int r, input bit use_op);
    if (!pipe[m][1].vld || !use_op) return 0;
    for (int s = 2; s <= depth_m[m]; s++)
      if (mmatch(m, s, r) && (!pipe[m][s].load || s >= 2 + ll_m[m])) return s;
    return 0;
  endfunction

  function automatic void model_step(input int m, input bit v, input int rs, input int rt,
                                     input bit urs, input bit urt, input int dst,
                                     input bit rw, input bit ld, input bit br);
    bit   stall;
    bit   eff;
    exp_t e;
    ent_t nw;
    stall = 1'b0;
    for (int s = 1; s <= ll_m[m]; s++)
      if (pipe[m][s].load && ((urs && mmatch(m, s, rs)) || (urt && mmatch(m, s, rt))))
        stall = 1'b1;
    stall = stall && v;
    eff   = stall && !br;
    e.m   = m;
    e.pcw = eff ? 0 : 1;
    e.ifw = eff ? 0 : 1;
    e.ifl = br ? 1 : 0;
    e.bub = (br || eff) ? 1 : 0;
    e.fa  = mfwd(m, pipe[m][1].rs, pipe[m][1].urs);
    e.fb  = mfwd(m, pipe[m][1].rt, pipe[m][1].urt);
    e.sc  = sc_m[m];
    e.fc  = fc_m[m];
    expq.push_back(e);
    for (int s = depth_m[m]; s >= 2; s--) begin
      pipe[m][s] = pipe[m][s-1];
      if (br && s < br_m[m]) pipe[m][s].vld = 1'b0;
    end
    nw = '{default: 0};
    if (v && !stall && !br) nw = '{1'b1, rw, ld, dst, rs, rt, urs, urt};
    pipe[m][1] = nw;
    if (eff && sc_m[m] < max_m[m]) sc_m[m]++;
    if (br && fc_m[m] < max_m[m]) fc_m[m]++;
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit ld, input bit br);
    bus3.id_valid_i = v;  bus5.id_valid_i = v;
    bus3.id_rs_i = 5'(rs); bus5.id_rs_i = 5'(rs);
    bus3.id_rt_i = 5'(rt); bus5.id_rt_i = 5'(rt);
    bus3.id_use_rs_i = urs; bus5.id_use_rs_i = urs;
    bus3.id_use_rt_i = urt; bus5.id_use_rt_i = urt;
    bus3.id_dst_i = 5'(dst); bus5.id_dst_i = 5'(dst);
    bus3.id_regwr_i = rw; bus5.id_regwr_i = rw;
    bus3.id_load_i = ld;  bus5.id_load_i = ld;
    bus3.branch_taken_i = br; bus5.branch_taken_i = br;
  endtask

  task automatic cycle(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit ld, input bit br);
    @(posedge clk);
    #1;
    drive(v, rs, rt, urs, urt, dst, rw, ld, br);
    model_step(0, v, rs, rt, urs, urt, dst, rw, ld, br);
    model_step(1, v, rs, rt, urs, urt, dst, rw, ld, br);
    txn++;
    $display("txn %0d: v=%0d rs=%0d rt=%0d use=%0d%0d dst=%0d wr=%0d ld=%0d br=%0d",
             txn, v, rs, rt, urs, urt, dst, rw, ld, br);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " pc_write d3"}, int'(bus3.pc_write_o), 1);
    chk({tag, " ifid_write d3"}, int'(bus3.ifid_write_o), 1);
    chk({tag, " ifid_flush d3"}, int'(bus3.ifid_flush_o), 0);
    chk({tag, " bubble d3"}, int'(bus3.idex_bubble_o), 0);
    chk({tag, " fwd_a d3"}, int'(bus3.fwd_a_sel_o), 0);
    chk({tag, " stall_cnt d3"}, int'(bus3.stall_cnt_o), 0);
    chk({tag, " flush_cnt d3"}, int'(bus3.flush_cnt_o), 0);
    chk({tag, " pc_write d5"}, int'(bus5.pc_write_o), 1);
    chk({tag, " bubble d5"}, int'(bus5.idex_bubble_o), 0);
    chk({tag, " fwd_b d5"}, int'(bus5.fwd_b_sel_o), 0);
    chk({tag, " stall_cnt d5"}, int'(bus5.stall_cnt_o), 0);
    chk({tag, " flush_cnt d5"}, int'(bus5.flush_cnt_o), 0);
  endtask

  // Monitor: the controller presents a full response every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    int a [8];
    string d;
    forever begin
      @(negedge clk);
      while (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.m == 0) begin
          d = "d3";
          a = '{int'(bus3.pc_write_o), int'(bus3.ifid_write_o), int'(bus3.ifid_flush_o),
                int'(bus3.idex_bubble_o), int'(bus3.fwd_a_sel_o), int'(bus3.fwd_b_sel_o),
                int'(bus3.stall_cnt_o), int'(bus3.flush_cnt_o)};
        end else begin
          d = "d5";
          a = '{int'(bus5.pc_write_o), int'(bus5.ifid_write_o), int'(bus5.ifid_flush_o),
                int'(bus5.idex_bubble_o), int'(bus5.fwd_a_sel_o), int'(bus5.fwd_b_sel_o),
                int'(bus5.stall_cnt_o), int'(bus5.flush_cnt_o)};
        end
        chk({"pc_write ", d}, a[0], e.pcw);
        chk({"ifid_write ", d}, a[1], e.ifw);
        chk({"ifid_flush ", d}, a[2], e.ifl);
        chk({"idex_bubble ", d}, a[3], e.bub);
        chk({"fwd_a_sel ", d}, a[4], e.fa);
        chk({"fwd_b_sel ", d}, a[5], e.fb);
        chk({"stall_cnt ", d}, a[6], e.sc);
        chk({"flush_cnt ", d}, a[7], e.fc);
      end
    end
  end

  initial begin
    int guard;
    depth_m = '{3, 5};
    ll_m    = '{1, 2};
    br_m    = '{2, 3};
    max_m   = '{65535, 15};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_model();
    #12;
    check_reset_outputs("init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // lw r2 ; add r3,r2,r4 held in ID until it issues
    cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
    cycle(1, 2, 4, 1, 1, 3, 1, 0, 0);
    cycle(1, 2, 4, 1, 1, 3, 1, 0, 0);
    cycle(1, 2, 4, 1, 1, 3, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add r1 ; sub r5,r1,r1
    cycle(1, 6, 7, 1, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 1, 5, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // two producers of r1, youngest must win; then r0 never forwards
    cycle(1, 0, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 1, 3, 1, 1, 6, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 1, 7, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // branch taken while a load-use stall is pending
    cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
    cycle(1, 2, 2, 1, 1, 3, 1, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    // reset asserted between edges while a load-use stall is active
    cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
    cycle(1, 2, 0, 1, 0, 3, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    reset_model();
    cycle(1, 2, 0, 1, 0, 3, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("scoreboard drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
